exec_sequencer: RTL and testbench

- Multi-cycle fetch/decode/execute/writeback controller that sequences the decode/ALU datapath and the register file.
- Fetches 32-bit instructions over a valid/ready instruction-memory port.
- Presents each instruction to the decoder, drives register-file read/write addresses, captures the ALU result and commits it.
- Sits between instruction memory and the decode/regfile pair. Provides PC, status and retire count to the top level.

---
 rtl/exec_sequencer.sv | 134 +++++++++++++
 tb/tb_exec_sequencer.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/exec_sequencer.sv
// exec_sequencer
// Multi-cycle fetch/decode/execute/writeback controller. Fetches 32-bit
// instructions over a valid/ready instruction-memory port, holds the current
// instruction for the decoder, drives register-file addresses, captures the
// ALU result in EXEC and commits it in WB.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   start                 begin / restart execution (IDLE or HALT only)
//   imem_req/addr         fetch request and address (address equals pc)
//   imem_ready/rdata      memory handshake and returned instruction
//   instr                 instruction register
//   rf_raddr1/2           source register addresses from instr
//   rf_we/waddr/wdata     register-file write port (write only in WB)
//   alu_result            result from the execute datapath
//   pc, busy, halted      program counter and status
//   illegal               sticky flag: halted on an unsupported opcode
//   retired               count of committed instructions
module exec_sequencer #(
  parameter int          N        = 32,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  output logic         imem_req,
  output logic [31:0]  imem_addr,
  input  logic         imem_ready,
  input  logic [31:0]  imem_rdata,
  output logic [31:0]  instr,
  output logic [4:0]   rf_raddr1,
  output logic [4:0]   rf_raddr2,
  output logic         rf_we,
  output logic [4:0]   rf_waddr,
  output logic [N-1:0] rf_wdata,
  input  logic [N-1:0] alu_result,
  output logic [31:0]  pc,
  output logic         busy,
  output logic         halted,
  output logic         illegal,
  output logic [31:0]  retired
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_WB,
    S_HALT
  } state_t;

  localparam logic [6:0]  OP_RTYPE = 7'b0110011;
  localparam logic [6:0]  OP_ITYPE = 7'b0010011;
  localparam logic [31:0] ECALL    = 32'h0000_0073;

  state_t         state_reg;
  logic [31:0]    pc_reg;
  logic [31:0]    instr_reg;
  logic [31:0]    retired_reg;
  logic [N-1:0]   wdata_reg;
  logic           illegal_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= S_IDLE;
      pc_reg      <= RESET_PC;
      instr_reg   <= 32'h0;
      retired_reg <= 32'h0;
      wdata_reg   <= '0;
      illegal_reg <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (start) state_reg <= S_FETCH;
        end
        S_FETCH: begin
          // Request stays up with a stable address until memory accepts it.
          if (imem_ready) begin
            instr_reg <= imem_rdata;
            state_reg <= S_DECODE;
          end
        end
        S_DECODE: begin
          if (instr_reg[6:0] == OP_RTYPE || instr_reg[6:0] == OP_ITYPE) begin
            state_reg <= S_EXEC;
          end else if (instr_reg == ECALL) begin
            state_reg <= S_HALT;
          end else begin
            state_reg   <= S_HALT;
            illegal_reg <= 1'b1;
          end
        end
        S_EXEC: begin
          wdata_reg <= alu_result;
          state_reg <= S_WB;
        end
        S_WB: begin
          // Commit: both counters wrap naturally at 2^32.
          pc_reg      <= pc_reg + 32'd4;
          retired_reg <= retired_reg + 32'd1;
          state_reg   <= S_FETCH;
        end
        S_HALT: begin
          if (start) begin
            pc_reg      <= RESET_PC;
            illegal_reg <= 1'b0;
            state_reg   <= S_FETCH;
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  // Outputs decode from state and the instruction register only, so there is
  // no combinational path from imem_ready or alu_result.
  assign imem_req  = (state_reg == S_FETCH);
  assign imem_addr = pc_reg;
  assign instr     = instr_reg;
  assign rf_raddr1 = instr_reg[19:15];
  assign rf_raddr2 = instr_reg[24:20];
  assign rf_waddr  = instr_reg[11:7];
  // x0 is hard-wired zero, so a write to it is suppressed.
  assign rf_we     = (state_reg == S_WB) && (instr_reg[11:7] != 5'd0);
  assign rf_wdata  = wdata_reg;
  assign pc        = pc_reg;
  assign busy      = (state_reg == S_FETCH) || (state_reg == S_DECODE) ||
                     (state_reg == S_EXEC)  || (state_reg == S_WB);
  assign halted    = (state_reg == S_HALT);
  assign illegal   = illegal_reg;
  assign retired   = retired_reg;

endmodule

// File: tb/tb_exec_sequencer.sv
module tb_exec_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [4:0]  rf_raddr1;
  logic [4:0]  rf_raddr2;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [31:0] alu_result;
  logic [31:0] pc;
  logic        busy;
  logic        halted;
  logic        illegal;
  logic [31:0] retired;

  exec_sequencer #(.N(32), .RESET_PC(32'h0000_0000)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ready (imem_ready),
    .imem_rdata (imem_rdata),
    .instr      (instr),
    .rf_raddr1  (rf_raddr1),
    .rf_raddr2  (rf_raddr2),
    .rf_we      (rf_we),
    .rf_waddr   (rf_waddr),
    .rf_wdata   (rf_wdata),
    .alu_result (alu_result),
    .pc         (pc),
    .busy       (busy),
    .halted     (halted),
    .illegal    (illegal),
    .retired    (retired)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_halt;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [31:0] pc;
    logic [31:0] retired;
    bit          ill;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] last_instr;
  logic        prev_halted = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic push_wr(input logic [4:0] a, input logic [31:0] d,
                         input logic [31:0] p, input logic [31:0] r);
    exp_t e;
    e.is_halt = 1'b0; e.waddr = a; e.wdata = d; e.pc = p; e.retired = r; e.ill = 1'b0;
    sb.push_back(e);
  endtask

  task automatic push_halt(input logic [31:0] p, input logic [31:0] r, input bit il);
    exp_t e;
    e.is_halt = 1'b1; e.waddr = 5'd0; e.wdata = 32'h0; e.pc = p; e.retired = r; e.ill = il;
    sb.push_back(e);
  endtask

  // Monitor: every write pulse and every entry into HALT is a transaction.
  always @(negedge clk) begin
    exp_t e;
    if (rf_we === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_write", {27'd0, rf_waddr}, 32'hFFFF_FFFF);
      end else begin
        e = sb.pop_front();
        $display("monitor write x%0d=%h pc=%h retired=%0d", rf_waddr, rf_wdata, pc, retired);
        chk("wr_kind", {31'd0, e.is_halt}, 32'd0);
        chk("wr_addr", {27'd0, rf_waddr}, {27'd0, e.waddr});
        chk("wr_data", rf_wdata, e.wdata);
        chk("wr_pc", pc, e.pc);
        chk("wr_retired", retired, e.retired);
      end
    end
    if (halted === 1'b1 && prev_halted == 1'b0) begin
      if (sb.size() == 0) begin
        chk("unexpected_halt", 32'd1, 32'd0 + {31'd0, halted} - 32'd1);
      end else begin
        e = sb.pop_front();
        $display("monitor halt pc=%h illegal=%0b retired=%0d", pc, illegal, retired);
        chk("halt_kind", {31'd0, e.is_halt}, 32'd1);
        chk("halt_pc", pc, e.pc);
        chk("halt_illegal", {31'd0, illegal}, {31'd0, e.ill});
        chk("halt_retired", retired, e.retired);
      end
    end
    prev_halted = (halted === 1'b1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req();
    int n = 0;
    while (imem_req !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    chk("fetch_req", {31'd0, imem_req}, 32'd1);
  endtask

  // Leaves the DUT in DECODE with the new instruction latched.
  task automatic fetch(input logic [31:0] addr, input logic [31:0] word,
                       input logic [31:0] alu, input int stall);
    wait_req();
    for (int i = 0; i < stall; i++) begin
      imem_ready = 1'b0;
      imem_rdata = 32'hBAD0_0000 + i;
      chk("stall_req", {31'd0, imem_req}, 32'd1);
      chk("stall_addr", imem_addr, addr);
      chk("stall_instr", instr, last_instr);
      step();
    end
    imem_ready = 1'b1;
    imem_rdata = word;
    alu_result = alu;
    chk("fetch_addr", imem_addr, addr);
    step();
    imem_ready = 1'b0;
    imem_rdata = 32'hBAD0_FFFF;
    chk("decode_req", {31'd0, imem_req}, 32'd0);
    chk("decode_instr", instr, word);
    last_instr = word;
  endtask

  // From DECODE through EXEC into WB; rf_we must rise only in WB.
  task automatic exec_wb(input logic we_exp);
    chk("decode_we", {31'd0, rf_we}, 32'd0);
    step();
    chk("exec_we", {31'd0, rf_we}, 32'd0);
    chk("exec_busy", {31'd0, busy}, 32'd1);
    step();
    chk("wb_we", {31'd0, rf_we}, {31'd0, we_exp});
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; imem_ready = 1'b0;
    imem_rdata = 32'h0; alu_result = 32'h0; last_instr = 32'h0;
    step(); step();
    rst = 1'b0;
    step();
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_pc", pc, 32'h0);
    chk("rst_retired", retired, 32'h0);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_illegal", {31'd0, illegal}, 32'd0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_we", {31'd0, rf_we}, 32'd0);

    // add x1,x1,x2 with no memory wait.
    push_wr(5'd1, 32'h0000_0005, 32'h0, 32'd0);
    start = 1'b1; step(); start = 1'b0;
    chk("start_req", {31'd0, imem_req}, 32'd1);
    fetch(32'h0, 32'h0020_80B3, 32'h0000_0005, 0);
    chk("raddr1", {27'd0, rf_raddr1}, 32'd1);
    chk("raddr2", {27'd0, rf_raddr2}, 32'd2);
    exec_wb(1'b1);
    step();
    chk("add_pc", pc, 32'h4);
    chk("add_retired", retired, 32'd1);
    chk("add_next_addr", imem_addr, 32'h4);
    chk("add_next_req", {31'd0, imem_req}, 32'd1);
    chk("add_next_we", {31'd0, rf_we}, 32'd0);

    // add x0,x0,x0 after a 3-cycle stall; start pulsed while busy is ignored.
    start = 1'b1;
    fetch(32'h4, 32'h0000_0033, 32'h0000_1234, 3);
    start = 1'b0;
    exec_wb(1'b0);
    step();
    chk("x0_pc", pc, 32'h8);
    chk("x0_retired", retired, 32'd2);

    // ecall halts cleanly.
    push_halt(32'h8, 32'd2, 1'b0);
    fetch(32'h8, 32'h0000_0073, 32'h0, 0);
    step();
    chk("ecall_halted", {31'd0, halted}, 32'd1);
    chk("ecall_busy", {31'd0, busy}, 32'd0);
    chk("ecall_pc", pc, 32'h8);
    step(); step();
    chk("halt_hold_req", {31'd0, imem_req}, 32'd0);
    chk("halt_hold_retired", retired, 32'd2);

    // Restart, then an unsupported load opcode.
    push_halt(32'h0, 32'd2, 1'b1);
    start = 1'b1; step(); start = 1'b0;
    chk("restart_pc", pc, 32'h0);
    chk("restart_busy", {31'd0, busy}, 32'd1);
    fetch(32'h0, 32'h0000_0003, 32'h0, 0);
    step();
    chk("illegal_halted", {31'd0, halted}, 32'd1);
    chk("illegal_flag", {31'd0, illegal}, 32'd1);

    // Restart clears illegal; addi x2,x1,10.
    push_wr(5'd2, 32'hDEAD_BEEF, 32'h0, 32'd2);
    start = 1'b1; step(); start = 1'b0;
    chk("clear_illegal", {31'd0, illegal}, 32'd0);
    chk("clear_addr", imem_addr, 32'h0);
    chk("clear_retired", retired, 32'd2);
    fetch(32'h0, 32'h00A0_8113, 32'hDEAD_BEEF, 0);
    chk("addi_raddr1", {27'd0, rf_raddr1}, 32'd1);
    chk("addi_raddr2", {27'd0, rf_raddr2}, 32'd10);
    exec_wb(1'b1);
    step();
    chk("addi_pc", pc, 32'h4);
    chk("addi_retired", retired, 32'd3);

    // Reset asserted while in WB.
    push_wr(5'd3, 32'h0000_0077, 32'h4, 32'd3);
    fetch(32'h4, 32'h0020_81B3, 32'h0000_0077, 1);
    exec_wb(1'b1);
    rst = 1'b1; step(); rst = 1'b0;
    chk("mrst_we", {31'd0, rf_we}, 32'd0);
    chk("mrst_pc", pc, 32'h0);
    chk("mrst_retired", retired, 32'd0);
    chk("mrst_req", {31'd0, imem_req}, 32'd0);
    chk("mrst_busy", {31'd0, busy}, 32'd0);
    chk("mrst_wdata", rf_wdata, 32'h0);
    step();
    chk("mrst_idle_req", {31'd0, imem_req}, 32'd0);
    chk("sb_empty", sb.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
